// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and pointer helper for the rr_arb8 round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Search start that follows a winner: idx+1 with 7 wrapping to 0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_REQ - 1)) ? IDX_W'(0) : IDX_W'(idx + IDX_W'(1));
  endfunction

endpackage

// File: rtl/idx_onehot_dec.sv
// Combinational 3-to-8 decoder with enable.
// Ports:
//   en       - when 0 the output is all-zero
//   idx      - binary index to decode
//   onehot_c - one-hot image of idx, gated by en
module idx_onehot_dec
  import arb_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) begin
      onehot_c = N_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with registered grant index/valid and a
// one-hot grant decoded from them.
// Optional feature macro: ARB_TIMEOUT_EN enables the MAX_HOLD hold counter and the
// timeout pulse; without it the owner keeps the grant until it drops req or en falls.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   en      - global enable; 0 withdraws the grant and freezes arbitration
//   req     - level-sensitive request vector
//   gnt     - one-hot grant (zero when nothing is granted)
//   gnt_idx - binary index of the current/last owner
//   gnt_vld - high while a grant is active
//   timeout - one-cycle pulse when MAX_HOLD forces a rotation
module rr_arb8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam int unsigned HOLD_W = 8;

  // Elaboration-time guard on the hold limit.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb8: MAX_HOLD must be within 2..255");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0] win_idx_c;
  logic             do_grant_c;
  logic             hold_ok_c;
`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  // Rotating priority search: first set req bit at ptr, ptr+1, ... (mod 8).
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found     = 1'b0;
    cand      = ptr_q;
    win_idx_c = ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'(ptr_q + IDX_W'(k));
      if (!found && req[cand]) begin
        found     = 1'b1;
        win_idx_c = cand;
      end
    end
  end

  // Hold limit check; always satisfied when the counter is not built.
`ifdef ARB_TIMEOUT_EN
  assign hold_ok_c = (hold_cnt_q < HOLD_W'(MAX_HOLD - 1));
`else
  assign hold_ok_c = 1'b1;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    do_grant_c = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    if (!en) begin
      // ptr and hold count are kept; the count is cleared by the next grant.
      state_d   = IDLE;
      gnt_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          do_grant_c = |req;
        end
        GRANT: begin
          if (req[gnt_idx_q] && hold_ok_c) begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt_d = HOLD_W'(hold_cnt_q + HOLD_W'(1));
`endif
          end else begin
            // Release wins over timeout: pulse only if the owner still requests.
`ifdef ARB_TIMEOUT_EN
            timeout_d = req[gnt_idx_q];
`endif
            if (|req) begin
              do_grant_c = 1'b1;
            end else begin
              state_d   = IDLE;
              gnt_vld_d = 1'b0;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          gnt_vld_d = 1'b0;
        end
      endcase
    end

    if (do_grant_c) begin
      state_d   = GRANT;
      gnt_idx_d = win_idx_c;
      gnt_vld_d = 1'b1;
      ptr_d     = next_ptr(win_idx_c);
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = '0;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // One-hot grant derived from the registered index and valid.
  idx_onehot_dec u_dec (
    .en       (gnt_vld_q),
    .idx      (gnt_idx_q),
    .onehot_c (gnt)
  );

  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
